// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single register-file write port between core writeback and queued photon
// writes, with a starvation-forced drain and per-register pending flags for decode interlock.
module regfile_wr_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     Rst,
  input  logic                     core_we,
  input  logic [4:0]               core_rd,
  input  logic [31:0]              core_data,
  output logic                     core_stall,
  input  logic                     ph_valid,
  output logic                     ph_ready,
  input  logic [4:0]               ph_rd,
  input  logic [31:0]              ph_data,
  input  logic [4:0]               rs1_adr,
  input  logic [4:0]               rs2_adr,
  output logic                     rs1_pending,
  output logic                     rs2_pending,
  output logic                     rf_we,
  output logic [4:0]               rf_addr,
  output logic [31:0]              rf_wdata,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [0:0] {StNormal, StForce} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   rptr_q, wptr_q;
  logic [AW:0]     level_q, level_d;
  logic [4:0]      rd_mem   [DEPTH];
  logic [31:0]     data_mem [DEPTH];

  logic core_req, empty, full, push, pop;

  assign core_req   = core_we && (core_rd != 5'd0);
  assign empty      = (level_q == '0);
  assign full       = (level_q == (AW + 1)'(DEPTH));
  assign ph_ready   = !full && !Rst;
  // Writes to x0 complete the handshake but are never stored.
  assign push       = ph_valid && ph_ready && (ph_rd != 5'd0);
  assign fifo_level = level_q;

  always_comb begin
    rf_we      = 1'b0;
    rf_addr    = 5'd0;
    rf_wdata   = 32'd0;
    core_stall = 1'b0;
    pop        = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (!Rst) begin
      unique case (state_q)
        StNormal: begin
          if (core_req) begin
            rf_we    = 1'b1;
            rf_addr  = core_rd;
            rf_wdata = core_data;
            if (!empty) begin
              if (cnt_q == CW'(STARVE_MAX - 1)) begin
                state_d = StForce;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end else begin
              cnt_d = '0;
            end
          end else begin
            cnt_d = '0;
            if (!empty) begin
              pop      = 1'b1;
              rf_we    = 1'b1;
              rf_addr  = rd_mem[rptr_q];
              rf_wdata = data_mem[rptr_q];
            end
          end
        end
        StForce: begin
          core_stall = 1'b1;
          state_d    = StNormal;
          cnt_d      = '0;
          if (!empty) begin
            pop      = 1'b1;
            rf_we    = 1'b1;
            rf_addr  = rd_mem[rptr_q];
            rf_wdata = data_mem[rptr_q];
          end
        end
        default: begin
          state_d = StNormal;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // An entry is live when its distance from the read pointer is below the level.
  always_comb begin
    logic [AW-1:0] off;
    rs1_pending = 1'b0;
    rs2_pending = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rptr_q;
      if ({1'b0, off} < level_q) begin
        if (rd_mem[i] == rs1_adr) rs1_pending = 1'b1;
        if (rd_mem[i] == rs2_adr) rs2_pending = 1'b1;
      end
    end
    if (Rst || rs1_adr == 5'd0) rs1_pending = 1'b0;
    if (Rst || rs2_adr == 5'd0) rs2_pending = 1'b0;
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StNormal;
      cnt_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wptr_q]   <= ph_rd;
      data_mem[wptr_q] <= ph_data;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench: table vectors, directed corner sequences and random traffic, all
// compared against a queue-based model of the arbiter.
module tb_regfile_wr_arbiter;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        core_we = 1'b0;
  logic [4:0]  core_rd = '0;
  logic [31:0] core_data = '0;
  logic        core_stall;
  logic        ph_valid = 1'b0;
  logic        ph_ready;
  logic [4:0]  ph_rd = '0;
  logic [31:0] ph_data = '0;
  logic [4:0]  rs1_adr = '0;
  logic [4:0]  rs2_adr = '0;
  logic        rs1_pending, rs2_pending;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic [2:0]  fifo_level;

  regfile_wr_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .Rst(Rst), .core_we(core_we), .core_rd(core_rd), .core_data(core_data),
    .core_stall(core_stall), .ph_valid(ph_valid), .ph_ready(ph_ready), .ph_rd(ph_rd),
    .ph_data(ph_data), .rs1_adr(rs1_adr), .rs2_adr(rs2_adr), .rs1_pending(rs1_pending),
    .rs2_pending(rs2_pending), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {logic [4:0] rd; logic [31:0] data;} ent_t;
  ent_t m_q[$];
  bit   m_force = 0;
  int   m_cnt = 0;

  logic        e_we, e_stall, e_ready, e_p1, e_p2;
  logic [4:0]  e_addr;
  logic [31:0] e_wdata;
  logic [2:0]  e_level;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_queue(input logic [4:0] a);
    if (a == 5'd0) return 0;
    foreach (m_q[i]) if (m_q[i].rd == a) return 1;
    return 0;
  endfunction

  task automatic calc();
    bit req;
    req = core_we && core_rd != 5'd0;
    e_we = 0; e_addr = 0; e_wdata = 0; e_stall = 0;
    e_ready = 0; e_p1 = 0; e_p2 = 0; e_level = 0;
    if (!Rst) begin
      e_ready = m_q.size() < DEPTH;
      e_p1    = in_queue(rs1_adr);
      e_p2    = in_queue(rs2_adr);
      e_level = 3'(m_q.size());
      if (m_force) begin
        e_stall = 1;
        if (m_q.size() > 0) begin e_we = 1; e_addr = m_q[0].rd; e_wdata = m_q[0].data; end
      end else if (req) begin
        e_we = 1; e_addr = core_rd; e_wdata = core_data;
      end else if (m_q.size() > 0) begin
        e_we = 1; e_addr = m_q[0].rd; e_wdata = m_q[0].data;
      end
    end
  endtask

  task automatic check_model();
    calc();
    chk("rf_we", rf_we, e_we);
    chk("rf_addr", rf_addr, e_addr);
    chk("rf_wdata", rf_wdata, e_wdata);
    chk("core_stall", core_stall, e_stall);
    chk("ph_ready", ph_ready, e_ready);
    chk("rs1_pending", rs1_pending, e_p1);
    chk("rs2_pending", rs2_pending, e_p2);
    chk("fifo_level", fifo_level, e_level);
  endtask

  task automatic model_update();
    bit req, ready;
    ent_t e;
    if (Rst) begin
      m_q.delete(); m_force = 0; m_cnt = 0;
    end else begin
      req   = core_we && core_rd != 5'd0;
      ready = m_q.size() < DEPTH;
      if (m_force) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        m_force = 0; m_cnt = 0;
      end else if (req) begin
        if (m_q.size() > 0) begin
          m_cnt++;
          if (m_cnt == STARVE_MAX) begin m_force = 1; m_cnt = 0; end
        end else m_cnt = 0;
      end else begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        m_cnt = 0;
      end
      if (ph_valid && ready && ph_rd != 5'd0) begin
        e.rd = ph_rd; e.data = ph_data; m_q.push_back(e);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    advance();
  endtask

  task automatic idle_inputs();
    core_we = 0; core_rd = 0; core_data = 0; ph_valid = 0; ph_rd = 0; ph_data = 0;
    rs1_adr = 0; rs2_adr = 0;
  endtask

  task automatic do_reset();
    Rst = 1;
    tick();
    Rst = 0;
  endtask

  typedef struct {
    logic we; logic [4:0] rd; logic [31:0] data; logic pv; logic [4:0] prd;
    logic x_we; logic [4:0] x_addr; logic [31:0] x_wdata; logic x_ready;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1, 5'd5,  32'hA5,       0, 5'd0, 1, 5'd5,  32'hA5,       1};
    vecs[1] = '{1, 5'd0,  32'hFF,       1, 5'd0, 0, 5'd0,  32'h0,        1};
    vecs[2] = '{0, 5'd9,  32'h1234,     0, 5'd0, 0, 5'd0,  32'h0,        1};
    vecs[3] = '{1, 5'd31, 32'hDEADBEEF, 0, 5'd0, 1, 5'd31, 32'hDEADBEEF, 1};
    vecs[4] = '{0, 5'd0,  32'h0,        1, 5'd0, 0, 5'd0,  32'h0,        1};

    idle_inputs();
    #2;
    // Outputs held inactive during reset even with requests present.
    core_we = 1; core_rd = 5'd4; ph_valid = 1; ph_rd = 5'd6;
    @(negedge clk);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_ph_ready", ph_ready, 1'b0);
    chk("rst_level", fifo_level, 3'd0);
    check_model();
    advance();
    idle_inputs();
    do_reset();

    foreach (vecs[i]) begin
      core_we = vecs[i].we; core_rd = vecs[i].rd; core_data = vecs[i].data;
      ph_valid = vecs[i].pv; ph_rd = vecs[i].prd; ph_data = 32'h77;
      @(negedge clk);
      chk("vec_rf_we", rf_we, vecs[i].x_we);
      chk("vec_rf_addr", rf_addr, vecs[i].x_addr);
      chk("vec_rf_wdata", rf_wdata, vecs[i].x_wdata);
      chk("vec_ph_ready", ph_ready, vecs[i].x_ready);
      chk("vec_stall", core_stall, 1'b0);
      check_model();
      advance();
    end
    idle_inputs();
    tick();
    chk("x0_push_level", fifo_level, 3'd0);

    // Collision: core wins, photon queued then drained on the idle cycle.
    core_we = 1; core_rd = 5'd3; core_data = 32'h33;
    ph_valid = 1; ph_rd = 5'd7; ph_data = 32'h11;
    tick();
    idle_inputs(); rs1_adr = 5'd7;
    @(negedge clk);
    chk("coll_rf_addr", rf_addr, 5'd7);
    chk("coll_rf_wdata", rf_wdata, 32'h11);
    chk("coll_pend_on_pop", rs1_pending, 1'b1);
    chk("coll_level", fifo_level, 3'd1);
    check_model();
    advance();
    @(negedge clk);
    chk("coll_pend_clear", rs1_pending, 1'b0);
    check_model();
    advance();

    // Fill to full under core traffic, then drain in order.
    for (int i = 0; i < 4; i++) begin
      core_we = 1; core_rd = 5'd1; core_data = 32'(i);
      ph_valid = 1; ph_rd = 5'(10 + i); ph_data = 32'(100 + i);
      tick();
    end
    @(negedge clk);
    chk("full_level", fifo_level, 3'd4);
    chk("full_ready", ph_ready, 1'b0);
    check_model();
    advance();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_addr", rf_addr, 5'(10 + i));
      chk("drain_data", rf_wdata, 32'(100 + i));
      check_model();
      advance();
    end
    tick();
    chk("drain_level", fifo_level, 3'd0);

    // Starvation: 8 core grants, one forced photon drain, then held core write.
    do_reset();
    core_we = 1; core_rd = 5'd2; core_data = 32'h22;
    ph_valid = 1; ph_rd = 5'd20; ph_data = 32'h2020;
    tick();
    ph_valid = 0; ph_rd = 0;
    for (int i = 0; i < STARVE_MAX; i++) begin
      @(negedge clk);
      chk("starve_core", rf_addr, 5'd2);
      chk("starve_nostall", core_stall, 1'b0);
      check_model();
      advance();
    end
    @(negedge clk);
    chk("force_stall", core_stall, 1'b1);
    chk("force_addr", rf_addr, 5'd20);
    check_model();
    advance();
    @(negedge clk);
    chk("force_after", rf_addr, 5'd2);
    chk("force_after_stall", core_stall, 1'b0);
    check_model();
    advance();

    // Reset mid-starvation flushes queue and counter.
    do_reset();
    core_we = 1; core_rd = 5'd8; core_data = 32'h88;
    for (int i = 0; i < 6; i++) begin
      ph_valid = (i < 3); ph_rd = 5'(24 + i); ph_data = 32'(i);
      tick();
    end
    chk("pre_rst_level", fifo_level, 3'd3);
    ph_valid = 0; ph_rd = 0;
    Rst = 1;
    #1;
    chk("async_rst_level", fifo_level, 3'd0);
    chk("async_rst_we", rf_we, 1'b0);
    tick();
    Rst = 0;
    for (int i = 0; i < STARVE_MAX + 2; i++) begin
      @(negedge clk);
      chk("post_rst_core", rf_addr, 5'd8);
      chk("post_rst_nostall", core_stall, 1'b0);
      check_model();
      advance();
    end

    // Random traffic with occasional reset.
    idle_inputs();
    for (int i = 0; i < 600; i++) begin
      Rst       = ($urandom_range(0, 59) == 0);
      core_we   = ($urandom_range(0, 3) != 0);
      core_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      core_data = $urandom;
      ph_valid  = ($urandom_range(0, 1) != 0);
      ph_rd     = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
      ph_data   = $urandom;
      rs1_adr   = 5'($urandom_range(0, 7));
      rs2_adr   = 5'($urandom_range(0, 7));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
